// File: rtl/spi_panel_ctrl.sv
// spi_panel_ctrl: front-panel controller that sits between the board buttons
// and spi_master.
// - Debounces four active-low buttons: increment, decrement, transmit and
//   display-mode.
// - Keeps an editable transmit word and runs a start/busy handshake toward
//   spi_master.
// - Captures the received word, flags a busy timeout and drives active-low
//   LEDs.
// Optional build macro AUTOREPEAT_EN: held increment/decrement buttons
// auto-repeat every 2^REPEAT_W cycles.
module spi_panel_ctrl #(
   parameter int DATA_W   = 8,
   parameter int LED_W    = 6,
   parameter int DEB_W    = 20,
   parameter int TMO_W    = 8,
   parameter int REPEAT_W = 22
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inc_n,
   input  logic              dec_n,
   input  logic              transmit_n,
   input  logic              mode_n,
   output logic              spi_start,
   output logic [DATA_W-1:0] spi_data_out,
   input  logic [DATA_W-1:0] spi_data_in,
   input  logic              spi_busy,
   output logic [LED_W-1:0]  led,
   output logic              busy,
   output logic              err
);

   // Button slots inside the 4-bit button vectors
   localparam int BTN_INC  = 0;
   localparam int BTN_DEC  = 1;
   localparam int BTN_TX   = 2;
   localparam int BTN_MODE = 3;

   localparam logic [DEB_W-1:0]  DEB_ONE   = {{(DEB_W-1){1'b0}}, 1'b1};
   localparam logic [DATA_W-1:0] DATA_ONE  = {{(DATA_W-1){1'b0}}, 1'b1};
   localparam logic [TMO_W-1:0]  TMO_ONE   = {{(TMO_W-1){1'b0}}, 1'b1};
   // Last count value before the timeout fires; firing here gives exactly
   // 2^TMO_W-1 WAIT_BUSY cycles.
   localparam logic [TMO_W-1:0]  TMO_LAST  = {{(TMO_W-1){1'b1}}, 1'b0};

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_START     = 2'd1,
      ST_WAIT_BUSY = 2'd2,
      ST_WAIT_DONE = 2'd3
   } state_t;

   logic [3:0]        btn_raw_s;
   logic [3:0]        sync1_q;
   logic [3:0]        sync2_q;
   logic [DEB_W-1:0]  deb_cnt_q [4];
   logic [DEB_W-1:0]  deb_cnt_d [4];
   logic [3:0]        held_s;
   logic [3:0]        held_dly_q;
   logic [3:0]        press_s;
   logic              inc_ev_s;
   logic              dec_ev_s;

   logic [DATA_W-1:0] tx_data_q;
   logic [DATA_W-1:0] rx_data_q;
   logic              led_sel_q;
   logic [LED_W-1:0]  led_q;

   state_t            state_q;
   logic              spi_start_q;
   logic              busy_q;
   logic              err_q;
   logic [DATA_W-1:0] spi_data_out_q;
   logic [TMO_W-1:0]  tmo_q;

   // Received bits above the LED width are captured but never displayed
   logic              unused_rx_s;
   assign unused_rx_s = ^rx_data_q;

   assign btn_raw_s = {mode_n, transmit_n, dec_n, inc_n};

   // Two-flop synchroniser per button; idle level is released (1)
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 4'b1111;
         sync2_q <= 4'b1111;
      end else begin
         sync1_q <= btn_raw_s;
         sync2_q <= sync1_q;
      end
   end

   // Debounce next count: clear on release, count while low, saturate at MSB
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         deb_cnt_d[i] = deb_cnt_q[i];
         if (sync2_q[i]) begin
            deb_cnt_d[i] = '0;
         end else if (!deb_cnt_q[i][DEB_W-1]) begin
            deb_cnt_d[i] = deb_cnt_q[i] + DEB_ONE;
         end else begin
            deb_cnt_d[i] = deb_cnt_q[i];
         end
      end
   end

   // Debounce counters plus a delayed copy of each MSB for edge detection
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            deb_cnt_q[i] <= '0;
         end
         held_dly_q <= 4'b0000;
      end else begin
         for (int i = 0; i < 4; i++) begin
            deb_cnt_q[i] <= deb_cnt_d[i];
         end
         held_dly_q <= held_s;
      end
   end

   // Press event is the single cycle in which a counter MSB rises
   always_comb begin
      held_s  = 4'b0000;
      press_s = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         held_s[i] = deb_cnt_q[i][DEB_W-1];
      end
      press_s = held_s & ~held_dly_q;
   end

`ifdef AUTOREPEAT_EN
   localparam logic [REPEAT_W-1:0] REP_ONE = {{(REPEAT_W-1){1'b0}}, 1'b1};

   logic [REPEAT_W-1:0] rep_cnt_q [2];

   // Repeat counters run from the initial event while inc/dec stay held
   always_ff @(posedge clk) begin
      if (rst) begin
         rep_cnt_q[0] <= '0;
         rep_cnt_q[1] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (held_s[i]) begin
               rep_cnt_q[i] <= rep_cnt_q[i] + REP_ONE;
            end else begin
               rep_cnt_q[i] <= '0;
            end
         end
      end
   end

   // Initial press event, plus one extra event each time the counter wraps
   always_comb begin
      inc_ev_s = press_s[BTN_INC] |
                 (held_s[BTN_INC] & held_dly_q[BTN_INC] & (rep_cnt_q[0] == '0));
      dec_ev_s = press_s[BTN_DEC] |
                 (held_s[BTN_DEC] & held_dly_q[BTN_DEC] & (rep_cnt_q[1] == '0));
   end
`else
   localparam int unused_repeat_w = REPEAT_W;

   // Without auto-repeat every press yields exactly one event
   always_comb begin
      inc_ev_s = press_s[BTN_INC];
      dec_ev_s = press_s[BTN_DEC];
   end
`endif

   // Transmit word editing, LED source select and registered LED drive
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_data_q <= '0;
         led_sel_q <= 1'b0;
         led_q     <= '1;
      end else begin
         case ({inc_ev_s, dec_ev_s})
            2'b10:   tx_data_q <= tx_data_q + DATA_ONE;
            2'b01:   tx_data_q <= tx_data_q - DATA_ONE;
            default: tx_data_q <= tx_data_q;
         endcase
         if (press_s[BTN_MODE]) begin
            led_sel_q <= ~led_sel_q;
         end else begin
            led_sel_q <= led_sel_q;
         end
         if (led_sel_q) begin
            led_q <= ~rx_data_q[LED_W-1:0];
         end else begin
            led_q <= ~tx_data_q[LED_W-1:0];
         end
      end
   end

   // Start/busy handshake FSM with registered start, busy, error and data
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         spi_start_q    <= 1'b0;
         busy_q         <= 1'b0;
         err_q          <= 1'b0;
         spi_data_out_q <= '0;
         rx_data_q      <= '0;
         tmo_q          <= '0;
      end else begin
         spi_start_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (press_s[BTN_TX]) begin
                  spi_data_out_q <= tx_data_q;
                  spi_start_q    <= 1'b1;
                  busy_q         <= 1'b1;
                  state_q        <= ST_START;
               end else begin
                  busy_q <= 1'b0;
               end
            end
            ST_START: begin
               tmo_q   <= '0;
               busy_q  <= 1'b1;
               state_q <= ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
               if (spi_busy) begin
                  state_q <= ST_WAIT_DONE;
               end else if (tmo_q == TMO_LAST) begin
                  err_q   <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end else begin
                  tmo_q <= tmo_q + TMO_ONE;
               end
            end
            ST_WAIT_DONE: begin
               if (!spi_busy) begin
                  rx_data_q <= spi_data_in;
                  err_q     <= 1'b0;
                  busy_q    <= 1'b0;
                  state_q   <= ST_IDLE;
               end else begin
                  busy_q <= 1'b1;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign spi_start    = spi_start_q;
   assign spi_data_out = spi_data_out_q;
   assign led          = led_q;
   assign busy         = busy_q;
   assign err          = err_q;

endmodule

// File: tb/tb_spi_panel_ctrl.sv
// Scoreboard bench for spi_panel_ctrl (DEB_W=4, TMO_W=4, DATA_W=8, LED_W=6).
// Transfers push expected data/err/length into queues; a monitor pops and
// compares on each spi_start pulse and on each busy falling edge.
module tb_spi_panel_ctrl;

   localparam int DATA_W   = 8;
   localparam int LED_W    = 6;
   localparam int DEB_W    = 4;
   localparam int TMO_W    = 4;
   localparam int REPEAT_W = 6;

   logic              clk;
   logic              rst;
   logic              inc_n;
   logic              dec_n;
   logic              transmit_n;
   logic              mode_n;
   logic              spi_start;
   logic [DATA_W-1:0] spi_data_out;
   logic [DATA_W-1:0] spi_data_in;
   logic              spi_busy;
   logic [LED_W-1:0]  led;
   logic              busy;
   logic              err;

   int checks   = 0;
   int failures = 0;

   logic [7:0] exp_data_q[$];
   logic       exp_err_q[$];
   int         exp_len_q[$];

   int         model_busy_len;
   logic [7:0] model_rx;

   logic [7:0] cur_data;
   logic       start_prev;
   logic       busy_prev;
   int         busy_cnt;

   spi_panel_ctrl #(
      .DATA_W(DATA_W), .LED_W(LED_W), .DEB_W(DEB_W),
      .TMO_W(TMO_W), .REPEAT_W(REPEAT_W)
   ) dut (
      .clk(clk), .rst(rst), .inc_n(inc_n), .dec_n(dec_n),
      .transmit_n(transmit_n), .mode_n(mode_n), .spi_start(spi_start),
      .spi_data_out(spi_data_out), .spi_data_in(spi_data_in),
      .spi_busy(spi_busy), .led(led), .busy(busy), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic set_btn(input int which, input logic v);
      case (which)
         0: inc_n = v;
         1: dec_n = v;
         2: transmit_n = v;
         3: mode_n = v;
         default: begin
            inc_n = v;
            dec_n = v;
         end
      endcase
   endtask

   // One clean press: 14 cycles low, 6 cycles released
   task automatic press(input int which);
      @(negedge clk);
      set_btn(which, 1'b0);
      repeat (14) @(negedge clk);
      set_btn(which, 1'b1);
      repeat (6) @(negedge clk);
   endtask

   task automatic expect_xfer(input logic [7:0] d, input logic e, input int len);
      exp_data_q.push_back(d);
      exp_err_q.push_back(e);
      exp_len_q.push_back(len);
   endtask

   // SPI master model: raises busy 2 cycles after the start pulse
   initial begin
      spi_busy    = 1'b0;
      spi_data_in = 8'h00;
      forever begin
         @(negedge clk);
         if (spi_start === 1'b1 && model_busy_len > 0) begin
            repeat (2) @(negedge clk);
            spi_busy    = 1'b1;
            spi_data_in = model_rx;
            repeat (model_busy_len) @(negedge clk);
            spi_busy = 1'b0;
         end
      end
   end

   // Monitor: checks start pulses and transfer completions against queues
   initial begin
      start_prev = 1'b0;
      busy_prev  = 1'b0;
      busy_cnt   = 0;
      cur_data   = 8'h00;
      forever begin
         @(negedge clk);
         if (rst) begin
            start_prev = 1'b0;
            busy_prev  = 1'b0;
            busy_cnt   = 0;
         end else begin
            if (start_prev) check("start_width", {31'd0, spi_start}, 32'd0);
            if (spi_start) begin
               if (exp_data_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_start actual=1 required=0");
               end else begin
                  cur_data = exp_data_q.pop_front();
                  check("spi_data_out", {24'd0, spi_data_out}, {24'd0, cur_data});
               end
            end
            if (busy) busy_cnt++;
            if (busy_prev && !busy) begin
               if (exp_err_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_done actual=1 required=0");
               end else begin
                  check("done_err", {31'd0, err}, {31'd0, exp_err_q.pop_front()});
                  check("busy_len", busy_cnt, exp_len_q.pop_front());
                  check("data_hold", {24'd0, spi_data_out}, {24'd0, cur_data});
               end
               busy_cnt = 0;
            end
            start_prev = spi_start;
            busy_prev  = busy;
         end
      end
   end

   // Directed stimulus
   initial begin
      rst            = 1'b1;
      inc_n          = 1'b1;
      dec_n          = 1'b1;
      transmit_n     = 1'b1;
      mode_n         = 1'b1;
      model_busy_len = 10;
      model_rx       = 8'h3C;

      repeat (2) @(negedge clk);
      check("rst_led", {26'd0, led}, 32'h3F);
      check("rst_start", {31'd0, spi_start}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      check("rst_data_out", {24'd0, spi_data_out}, 32'h00);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // Bouncy increment press: exactly one event
      for (int b = 0; b < 3; b++) begin
         inc_n = 1'b0;
         repeat (3) @(negedge clk);
         inc_n = 1'b1;
         @(negedge clk);
      end
      inc_n = 1'b0;
      repeat (20) @(negedge clk);
      inc_n = 1'b1;
      repeat (6) @(negedge clk);
      check("led_after_inc", {26'd0, led}, 32'h3E);

      // Two decrements: 0x01 -> 0xFF
      press(1);
      press(1);
      check("led_after_dec2", {26'd0, led}, 32'h00);

      // Simultaneous inc and dec: no change
      press(4);
      check("led_inc_dec_same", {26'd0, led}, 32'h00);

      // 0xFF down to 0xA5 (90 decrements)
      for (int k = 0; k < 90; k++) press(1);
      check("led_tx_a5", {26'd0, led}, 32'h1A);

      // Good transfer, rx 0x3C
      expect_xfer(8'hA5, 1'b0, 13);
      press(2);
      repeat (20) @(negedge clk);
      check("busy_idle_1", {31'd0, busy}, 32'd0);
      press(3);
      check("led_rx_3c", {26'd0, led}, 32'h03);
      press(3);
      check("led_back_tx", {26'd0, led}, 32'h1A);

      // Timeout transfer: spi_busy never rises
      model_busy_len = 0;
      expect_xfer(8'hA5, 1'b1, 16);
      press(2);
      repeat (30) @(negedge clk);
      check("err_timeout", {31'd0, err}, 32'd1);
      check("busy_after_tmo", {31'd0, busy}, 32'd0);

      // Following good transfer clears err, rx 0x55
      model_busy_len = 10;
      model_rx       = 8'h55;
      expect_xfer(8'hA5, 1'b0, 13);
      press(2);
      repeat (20) @(negedge clk);
      check("err_cleared", {31'd0, err}, 32'd0);
      press(3);
      check("led_rx_55", {26'd0, led}, 32'h2A);
      press(3);

      // Long transfer: second transmit dropped, then reset in WAIT_DONE
      model_busy_len = 60;
      exp_data_q.push_back(8'hA5);
      press(2);
      press(2);
      check("busy_wait_done", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_busy", {31'd0, busy}, 32'd0);
      check("rst_mid_start", {31'd0, spi_start}, 32'd0);
      check("rst_mid_led", {26'd0, led}, 32'h3F);
      check("rst_mid_err", {31'd0, err}, 32'd0);
      check("rst_mid_data", {24'd0, spi_data_out}, 32'h00);
      @(negedge clk);
      rst = 1'b0;
      repeat (60) @(negedge clk);
      check("final_busy", {31'd0, busy}, 32'd0);
      check("sb_data_empty", exp_data_q.size(), 32'd0);
      check("sb_err_empty", exp_err_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/spi_panel_ctrl.md
Name: spi_panel_ctrl

Overview:
- Parametrised successor to the board-level SPI front panel.
- Debounces four active-low push buttons: increment, decrement, transmit, display-mode.
- Maintains a DATA_W-bit transmit value and runs a start/busy handshake FSM toward the SPI master. Captures the received word and drives active-low LEDs.
- Sits between board pins and spi_master in the top level; adds decrement, received-data display, busy timeout and error flagging.

Parameters:
- DATA_W, 8, width of transmit/receive words.
- LED_W, 6, number of LEDs; must satisfy LED_W <= DATA_W.
- DEB_W, 20, debounce counter width; a press is accepted after 2^(DEB_W-1) stable-low cycles.
- TMO_W, 8, busy-timeout counter width; timeout fires at 2^TMO_W-1 cycles.
- REPEAT_W, 22, auto-repeat interval counter width (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- inc_n  in  1  increment button, active low, asynchronous to clk
- dec_n  in  1  decrement button, active low
- transmit_n  in  1  transmit button, active low
- mode_n  in  1  LED display-mode button, active low
- spi_start  out  1  one-cycle start pulse to spi_master
- spi_data_out  out  DATA_W  word presented to spi_master, stable from start until the transfer ends
- spi_data_in  in  DATA_W  word received by spi_master, valid when spi_busy falls
- spi_busy  in  1  spi_master transfer in progress
- led  out  LED_W  active-low LED drive
- busy  out  1  high whenever FSM is not IDLE
- err  out  1  sticky busy-timeout flag

Behaviour:
- Reset (sync, rst=1 at a clk edge):
  - sync flops = 1; debounce counters = 0.
  - tx_data, rx_data, spi_data_out = 0; led_sel = 0; led = all ones.
  - spi_start, busy, err = 0; FSM = IDLE.
  - Reset mid-transfer returns the FSM to IDLE next cycle. spi_master is not reset by this block.
- Input path: each button passes through a 2-flop synchroniser.
- Debounce, per button:
  - Counter clears to 0 while the synchronised input is 1.
  - While the input is 0, the counter increments until its MSB sets, then holds (saturates).
  - Press event = one-cycle pulse on the cycle the MSB goes 0->1.
  - Latency from stable low pin to event = 2 + 2^(DEB_W-1) cycles.
  - Bounce resets the count. Exactly one event per press.
- tx_data:
  - inc event: +1 mod 2^DATA_W (0xFF->0x00 at DATA_W=8).
  - dec event: -1 mod 2^DATA_W (0x00->0xFF).
  - inc and dec events in the same cycle: no change.
  - Editing is allowed in any FSM state; it does not affect a transfer already latched.
- mode event: toggles led_sel.
- led output: led = ~tx_data[LED_W-1:0] when led_sel=0, ~rx_data[LED_W-1:0] when led_sel=1. Registered, 1-cycle latency.
- FSM states IDLE, START, WAIT_BUSY, WAIT_DONE:
  - IDLE: on a transmit event, spi_data_out <= tx_data and go to START. Transmit events in any other state are dropped.
  - START: spi_start=1 for exactly this cycle; clear the timeout counter; go to WAIT_BUSY.
  - WAIT_BUSY: if spi_busy=1, go to WAIT_DONE. Otherwise increment the timeout counter; at 2^TMO_W-1, set err=1 and go to IDLE (rx_data unchanged).
  - WAIT_DONE: when spi_busy=0, rx_data <= spi_data_in, err <= 0, go to IDLE. No timeout in this state.
- busy = (state != IDLE). spi_start is low in every state except START.
- err is sticky: cleared only by rst or a completed transfer.

Optional Feature:
- Macro AUTOREPEAT_EN.
- Defined: while inc_n or dec_n stays debounced-low, a REPEAT_W-bit counter runs from the initial event and emits a further inc/dec event each time it wraps (every 2^REPEAT_W cycles) until release. Release clears the counter. transmit and mode never repeat.
- Undefined: the repeat counter logic is absent; one event per press only.

Test Plan (DEB_W=4, TMO_W=4, DATA_W=8, LED_W=6):
- rst high 2 cycles -> led=6'b111111, spi_start=0, busy=0, err=0, spi_data_out=0x00.
- inc_n low with 3 bounces then held 20 cycles -> exactly one event, tx_data=0x01, led=6'b111110. dec pressed twice -> tx_data=0xFF, led=6'b000000.
- inc_n and dec_n debounced in the same cycle -> tx_data unchanged.
- tx_data=0xA5, press transmit; model holds spi_busy high 10 cycles starting 2 cycles after the pulse with spi_data_in=0x3C:
  - spi_start high for exactly 1 cycle; spi_data_out=0xA5.
  - rx_data=0x3C; press mode -> led=~6'b111100=6'b000011.
- transmit with spi_busy tied 0 -> err=1 after 15 WAIT_BUSY cycles, FSM returns to IDLE. A following good transfer clears err.
- rst asserted during WAIT_DONE -> next cycle busy=0, spi_start=0, tx_data=0. A second transmit press during WAIT_DONE (without rst) is ignored.
